ex_mdu: RTL
===========

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 SHALL have the following ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse from the E-stage decoder for a MULT/MULTU/DIV/DIVU in E.
- mdOp  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 behave as NONE.
- rsData_E  input  32  rs operand from the ID/EX register, already forwarded.
- rtData_E  input  32  rt operand from the ID/EX register, already forwarded.
- busy  output  1  multiply/divide in progress; consumed by the stall unit.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.
- mdOut  output  32  E-stage result for MFHI/MFLO.

Function
REQ-003 SHALL accept start only when busy=0 and mdOp is 1-4; start while busy=1, or with any other mdOp, SHALL be ignored.
REQ-004 On an accepted start edge, SHALL latch the operands, compute the 64-bit result into internal temp registers, and load the cycle counter with 5 (MULT/MULTU) or 10 (DIV/DIVU).
REQ-005 busy SHALL be 1 for exactly N cycles (N=5 or 10), starting in the cycle after the accepted start edge; the counter SHALL decrement once per cycle while nonzero.
REQ-006 On the edge where the counter goes 1->0, SHALL commit temp HI/LO to hi/lo and deassert busy; the new hi/lo values SHALL be visible in the first cycle with busy=0.
REQ-007 MULT: {hi,lo} = signed rs * signed rt, full 64 bits. MULTU: the same computation, unsigned.
REQ-008 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend (DIV); operations are signed (DIV) or unsigned (DIVU).
REQ-009 DIV 0x80000000 / 0xFFFFFFFF SHALL commit lo=0x80000000 and hi=0.
REQ-010 A divide with rt=0 SHALL run the full 10 busy cycles and leave hi/lo unchanged.
REQ-011 MTHI/MTLO with busy=0 and start=0 SHALL write rsData_E to hi/lo on the next edge; when busy=1 they SHALL be ignored, because the stall unit guarantees they never reach E while busy.
REQ-012 mdOut SHALL be combinational: hi for MFHI, lo for MFLO, otherwise 0.
REQ-013 mdOut SHALL reflect the committed registers only, with no bypass of an in-flight result or of the same-cycle MTHI/MTLO.
REQ-014 hi and lo SHALL change only on a commit (REQ-006), MTHI/MTLO (REQ-011), or reset.
REQ-015 The stall contract, implemented outside this block, SHALL be: stall D when D holds an MD-class instruction (mdOp 1-8) and (start | busy)=1.
REQ-016 Operands SHALL be sampled only on the accepted start edge; later changes to rsData_E/rtData_E during busy SHALL NOT affect the result.

Reset
REQ-017 On reset, SHALL set hi=0, lo=0, busy=0, counter=0 and temp HI/LO=0 on the next edge.
REQ-018 Reset asserted mid-operation SHALL abort the operation with no commit; reset SHALL take priority over start, commit and MTHI/MTLO in the same cycle.

Verification
REQ-019 Scenario MULT: start, MULT, rs=0xFFFFFFFE, rt=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-020 Scenario MULTU: start, MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-021 Scenario DIV and DIVU: DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with rt=0 -> 10 busy cycles, hi/lo unchanged.
REQ-022 Scenario ignored start and operand change: start during busy, plus operand changes mid-op -> busy length and result match the first op only; no second op runs.
REQ-023 Scenario MT/MF: MTHI rs=0x12345678, then MFHI next cycle -> mdOut=0x12345678; MTLO during busy -> lo unchanged.
REQ-024 Scenario reset mid-op: reset at busy cycle 3 of a DIV -> busy=0, hi=lo=0 next cycle; no later commit.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu -- multiply/divide unit for the E stage of a MIPS-style pipeline.
//
// A MULT/MULTU/DIV/DIVU is accepted on a start pulse while idle. The 64-bit
// result is computed immediately into temp registers. A down-counter then
// keeps busy high for 5 (multiply) or 10 (divide) cycles. On the 1->0
// counter edge the temps are committed to the architectural HI/LO. MTHI/MTLO
// write HI/LO directly while idle. MFHI/MFLO read the committed registers
// combinationally.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle pulse for an MD arithmetic op in E
//   mdOp[3:0]         0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                     5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others NONE
//   rsData_E, rtData_E  forwarded operands
//   busy              operation in flight (to stall unit)
//   hi, lo            architectural HI/LO
//   mdOut             MFHI/MFLO result, 0 otherwise
module ex_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] rsData_E,
  input  logic [31:0] rtData_E,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d;
  logic [31:0] tmp_lo_q, tmp_lo_d;
  // Set for a divide by zero: the op still runs its full length but the
  // commit is suppressed so HI/LO keep their old values.
  logic        no_commit_q, no_commit_d;

  // Arithmetic datapath, evaluated from the live operands; its result is only
  // captured on an accepted start edge.
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] rs_mag, rt_mag, divisor, q_mag, r_mag, quot, rem;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed
    // 32x32 product.
    prod_s = {{32{rsData_E[31]}}, rsData_E} * {{32{rtData_E[31]}}, rtData_E};
    prod_u = {32'd0, rsData_E} * {32'd0, rtData_E};

    // Divide on magnitudes and fix the signs afterwards. This also gives
    // 0x80000000 / -1 = 0x80000000 rem 0 without relying on signed overflow.
    div_signed = (mdOp == OP_DIV);
    rs_mag  = (div_signed && rsData_E[31]) ? (32'd0 - rsData_E) : rsData_E;
    rt_mag  = (div_signed && rtData_E[31]) ? (32'd0 - rtData_E) : rtData_E;
    divisor = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    q_mag   = rs_mag / divisor;
    r_mag   = rs_mag % divisor;
    quot    = (div_signed && (rsData_E[31] ^ rtData_E[31])) ? (32'd0 - q_mag) : q_mag;
    rem     = (div_signed && rsData_E[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    tmp_hi_d    = tmp_hi_q;
    tmp_lo_d    = tmp_lo_q;
    no_commit_d = no_commit_q;

    if (cnt_q != 4'd0) begin
      // In flight: start and MTHI/MTLO are ignored.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && !no_commit_q) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end
    end else if (start) begin
      // A start with a non-arithmetic mdOp is dropped, and it also blocks
      // any same-cycle MTHI/MTLO.
      case (mdOp)
        OP_MULT: begin
          {tmp_hi_d, tmp_lo_d} = prod_s;
          no_commit_d = 1'b0;
          cnt_d = 4'd5;
        end
        OP_MULTU: begin
          {tmp_hi_d, tmp_lo_d} = prod_u;
          no_commit_d = 1'b0;
          cnt_d = 4'd5;
        end
        OP_DIV, OP_DIVU: begin
          tmp_hi_d = rem;
          tmp_lo_d = quot;
          no_commit_d = (rtData_E == 32'd0);
          cnt_d = 4'd10;
        end
        default: ;
      endcase
    end else if (mdOp == OP_MTHI) begin
      hi_d = rsData_E;
    end else if (mdOp == OP_MTLO) begin
      lo_d = rsData_E;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      tmp_hi_q    <= 32'd0;
      tmp_lo_q    <= 32'd0;
      no_commit_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      tmp_hi_q    <= tmp_hi_d;
      tmp_lo_q    <= tmp_lo_d;
      no_commit_q <= no_commit_d;
    end
  end

  assign busy = (cnt_q != 4'd0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Committed registers only: no bypass of in-flight or same-cycle writes.
  always_comb begin
    mdOut = 32'd0;
    if (mdOp == OP_MFHI)      mdOut = hi_q;
    else if (mdOp == OP_MFLO) mdOut = lo_q;
  end

endmodule
